// File: rtl/anim_pkg.sv
// Shared sprite-animation constants: sheet layout, frame counts, FSM encodings.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package anim_pkg;

    // Animation FSM states; the encoding is shared with the address generator.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WALK = 3'd1,
        ST_RISE = 3'd2,
        ST_FALL = 3'd3,
        ST_LAND = 3'd4
    } anim_state_t;

    // Sprite sheet selector as seen on the anim_sel output.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_WALK = 2'd1,
        SEL_JUMP = 2'd2
    } anim_sel_t;

    // Level controls from the physics / joystick side, bundled for the synchroniser.
    typedef struct packed {
        logic is_moving;
        logic jumping;
        logic on_ground;
    } ctl_t;

    // Registered sheet descriptor driven to the ROM address generator.
    typedef struct packed {
        anim_sel_t   sel;
        logic [14:0] base;
        logic [8:0]  width;
    } sheet_t;

    // Value presented to the FSM while the synchroniser still holds reset contents:
    // standing still on the ground, so nothing is inferred from flops that never saw the pins.
    localparam ctl_t CTL_NEUTRAL = '{is_moving: 1'b0, jumping: 1'b0, on_ground: 1'b1};

    localparam logic [14:0] BASE_IDLE  = 15'd4096;
    localparam logic [14:0] BASE_WALK  = 15'd8192;
    localparam logic [14:0] BASE_JUMP  = 15'd14336;
    localparam logic [8:0]  WIDTH_IDLE = 9'd128;
    localparam logic [8:0]  WIDTH_WALK = 9'd192;
    localparam logic [8:0]  WIDTH_JUMP = 9'd256;

    localparam int FRAMES_IDLE = 4;
    localparam int FRAMES_WALK = 6;
    localparam int FRAMES_JUMP = 8;

    // Frame indices; the jump sheet is split into rise, fall and landing segments.
    localparam logic [2:0] LAST_IDLE  = 3'(FRAMES_IDLE - 1);
    localparam logic [2:0] LAST_WALK  = 3'(FRAMES_WALK - 1);
    localparam logic [2:0] RISE_FIRST = 3'd0;
    localparam logic [2:0] RISE_LAST  = 3'd3;
    localparam logic [2:0] FALL_FIRST = 3'd4;
    localparam logic [2:0] FALL_LAST  = 3'd6;
    localparam logic [2:0] LAND_FRAME = 3'(FRAMES_JUMP - 1);

    function automatic anim_sel_t sel_of_state(input anim_state_t st);
        case (st)
            ST_IDLE: return SEL_IDLE;
            ST_WALK: return SEL_WALK;
            ST_RISE, ST_FALL, ST_LAND: return SEL_JUMP;
            default: return SEL_IDLE;
        endcase
    endfunction

    function automatic sheet_t sheet_of_sel(input anim_sel_t sel);
        case (sel)
            SEL_WALK: return '{sel: SEL_WALK, base: BASE_WALK, width: WIDTH_WALK};
            SEL_JUMP: return '{sel: SEL_JUMP, base: BASE_JUMP, width: WIDTH_JUMP};
            default:  return '{sel: SEL_IDLE, base: BASE_IDLE, width: WIDTH_IDLE};
        endcase
    endfunction

endpackage

// File: rtl/anim_sequencer_frame_ticker.sv
// Frame prescaler: counts 0..FRAME_DIV-1 and flags the terminal-count cycle as step.
// Latency: step is a decode of the count register; clear takes effect on the next edge.
// Backpressure: none; free-running except for clear.
module frame_ticker #(
    parameter int FRAME_DIV = 4000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic step
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(FRAME_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at terminal count.
    always_comb begin
        step  = (cnt_q == TERM);
        cnt_d = cnt_q + CW'(1);
        if (clear || step) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: picks idle/walk/jump sheet and frame from physics flags.
// Latency: 2 synchroniser cycles + 1 registered FSM/output cycle from raw inputs.
// Backpressure: none; level inputs, outputs update every cycle.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_DIV = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_moving,
    input  logic        jumping,
    input  logic        on_ground,
    output logic [1:0]  anim_sel,
    output logic [2:0]  frame_idx,
    output logic [14:0] sheet_base,
    output logic [8:0]  sheet_width,
    output logic        anim_change
);

    ctl_t        s1_q, s1_d;
    ctl_t        s2_q, s2_d;
    logic        jmp_prev_q, jmp_prev_d;
    logic [2:0]  vld_q, vld_d;
    anim_state_t state_q, state_d;
    logic [2:0]  frame_q, frame_d;
    sheet_t      sheet_q, sheet_d;
    logic        change_q, change_d;

    ctl_t        ctl;
    logic        prev_jmp;
    logic        jump_rise;
    logic        jump_fall;
    logic        step;
    logic        state_chg;

    // Double-flop synchroniser plus one extra jumping stage for edge detection.
    // vld tracks which stages hold post-reset samples so stale contents never drive the FSM.
    always_comb begin
        s1_d       = {is_moving, jumping, on_ground};
        s2_d       = s1_q;
        jmp_prev_d = s2_q.jumping;
        vld_d      = {vld_q[1:0], 1'b1};
        ctl        = vld_q[1] ? s2_q : CTL_NEUTRAL;
        prev_jmp   = vld_q[2] & jmp_prev_q;
        jump_rise  = ctl.jumping & ~prev_jmp;
        jump_fall  = ~ctl.jumping & prev_jmp;
    end

    // Frame prescaler, restarted on every state change so a new state gets a full first frame.
    frame_ticker #(
        .FRAME_DIV(FRAME_DIV)
    ) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .clear(state_chg),
        .step (step)
    );

    // Next-state and frame logic; a jump start overrides everything else.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        if (jump_rise) begin
            state_d = ST_RISE;
            frame_d = RISE_FIRST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ctl.on_ground && !ctl.jumping) begin
                        state_d = ST_FALL;
                        frame_d = FALL_FIRST;
                    end else if (ctl.is_moving) begin
                        state_d = ST_WALK;
                        frame_d = '0;
                    end else if (step) begin
                        frame_d = (frame_q == LAST_IDLE) ? 3'd0 : frame_q + 3'd1;
                    end
                end
                ST_WALK: begin
                    if (!ctl.on_ground && !ctl.jumping) begin
                        state_d = ST_FALL;
                        frame_d = FALL_FIRST;
                    end else if (!ctl.is_moving) begin
                        state_d = ST_IDLE;
                        frame_d = '0;
                    end else if (step) begin
                        frame_d = (frame_q == LAST_WALK) ? 3'd0 : frame_q + 3'd1;
                    end
                end
                ST_RISE: begin
                    // Ground contact alone does not end the ascent; only the jumping flag does.
                    if (jump_fall) begin
                        state_d = ST_FALL;
                        frame_d = FALL_FIRST;
                    end else if (step && frame_q < RISE_LAST) begin
                        frame_d = frame_q + 3'd1;
                    end
                end
                ST_FALL: begin
                    if (ctl.on_ground) begin
                        state_d = ST_LAND;
                        frame_d = LAND_FRAME;
                    end else if (step && frame_q < FALL_LAST) begin
                        frame_d = frame_q + 3'd1;
                    end
                end
                ST_LAND: begin
                    if (step) begin
                        state_d = ctl.is_moving ? ST_WALK : ST_IDLE;
                        frame_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    frame_d = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so sheet fields move together with anim_sel.
    always_comb begin
        state_chg = (state_d != state_q);
        change_d  = state_chg;
        sheet_d   = sheet_of_sel(sel_of_state(state_d));
    end

    // All state and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            jmp_prev_q <= 1'b0;
            vld_q      <= '0;
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            sheet_q    <= sheet_of_sel(SEL_IDLE);
            change_q   <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            jmp_prev_q <= jmp_prev_d;
            vld_q      <= vld_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            sheet_q    <= sheet_d;
            change_q   <= change_d;
        end
    end

    assign anim_sel    = sheet_q.sel;
    assign frame_idx   = frame_q;
    assign sheet_base  = sheet_q.base;
    assign sheet_width = sheet_q.width;
    assign anim_change = change_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer with FRAME_DIV = 4: directed table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_anim_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_moving = 1'b0;
    logic        jumping = 1'b0;
    logic        on_ground = 1'b1;
    logic [1:0]  anim_sel;
    logic [2:0]  frame_idx;
    logic [14:0] sheet_base;
    logic [8:0]  sheet_width;
    logic        anim_change;

    anim_sequencer #(.FRAME_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_moving  (is_moving),
        .jumping    (jumping),
        .on_ground  (on_ground),
        .anim_sel   (anim_sel),
        .frame_idx  (frame_idx),
        .sheet_base (sheet_base),
        .sheet_width(sheet_width),
        .anim_change(anim_change)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: animation mode plus time spent in it; frames follow from elapsed time.
    localparam int M_IDLE = 0, M_WALK = 1, M_RISE = 2, M_FALL = 3, M_LAND = 4;
    localparam bit [2:0] NEUT = 3'b001;   // {moving, jumping, on_ground}
    int       m_mode = M_IDLE;
    int       m_t = 0;
    bit       m_chg = 1'b0;
    bit [2:0] dl [3];                      // raw input history seen through the synchroniser

    task automatic model_edge(input bit r, input bit mv, input bit j, input bit og);
        bit [2:0] s;
        bit [2:0] p;
        bit       jr;
        bit       jf;
        int       nm;
        int       tn;
        if (r) begin
            m_mode = M_IDLE;
            m_t    = 0;
            m_chg  = 1'b0;
            dl[0]  = NEUT;
            dl[1]  = NEUT;
            dl[2]  = NEUT;
        end else begin
            s  = dl[1];
            p  = dl[2];
            jr = s[1] & ~p[1];
            jf = ~s[1] & p[1];
            tn = m_t + 1;
            nm = m_mode;
            if (jr) begin
                nm = M_RISE;
            end else begin
                case (m_mode)
                    M_IDLE:  if (!s[0] && !s[1]) nm = M_FALL; else if (s[2]) nm = M_WALK;
                    M_WALK:  if (!s[0] && !s[1]) nm = M_FALL; else if (!s[2]) nm = M_IDLE;
                    M_RISE:  if (jf) nm = M_FALL;
                    M_FALL:  if (s[0]) nm = M_LAND;
                    default: if (tn >= DIV) nm = s[2] ? M_WALK : M_IDLE;
                endcase
            end
            m_chg  = (nm != m_mode);
            m_t    = m_chg ? 0 : tn;
            m_mode = nm;
            dl[2]  = dl[1];
            dl[1]  = dl[0];
            dl[0]  = {mv, j, og};
        end
    endtask

    function automatic bit [29:0] model_out();
        int sel, fr, base, width, steps;
        steps = m_t / DIV;
        case (m_mode)
            M_IDLE:  begin sel = 0; fr = steps % 4; end
            M_WALK:  begin sel = 1; fr = steps % 6; end
            M_RISE:  begin sel = 2; fr = (steps > 3) ? 3 : steps; end
            M_FALL:  begin sel = 2; fr = 4 + ((steps > 2) ? 2 : steps); end
            default: begin sel = 2; fr = 7; end
        endcase
        base  = (sel == 0) ? 4096 : (sel == 1) ? 8192 : 14336;
        width = (sel == 0) ? 128 : (sel == 1) ? 192 : 256;
        return {2'(sel), 3'(fr), 15'(base), 9'(width), m_chg};
    endfunction

    function automatic bit [29:0] dut_out();
        return {anim_sel, frame_idx, sheet_base, sheet_width, anim_change};
    endfunction

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cyc(input bit r, input bit mv, input bit j, input bit og);
        bit [29:0] e;
        bit [29:0] a;
        int        lim;
        rst       = r;
        is_moving = mv;
        jumping   = j;
        on_ground = og;
        @(posedge clk);
        model_edge(r, mv, j, og);
        @(negedge clk);
        e = model_out();
        a = dut_out();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL model t=%0t got sel=%0d fr=%0d base=%0d w=%0d chg=%0d want sel=%0d fr=%0d base=%0d w=%0d chg=%0d",
                     $time, a[29:28], a[27:25], a[24:10], a[9:1], a[0], e[29:28], e[27:25], e[24:10], e[9:1], e[0]);
        end
        lim = (anim_sel == 2'd0) ? 3 : (anim_sel == 2'd1) ? 5 : (anim_sel == 2'd2) ? 7 : -1;
        n_cmp++;
        if (int'(frame_idx) > lim) begin
            n_bad++;
            $display("FAIL frame_bound t=%0t got frame=%0d sel=%0d want frame<=%0d", $time, frame_idx, anim_sel, lim);
        end
    endtask

    task automatic hold(input bit r, input bit mv, input bit j, input bit og, input int n);
        for (int i = 0; i < n; i++) cyc(r, mv, j, og);
    endtask

    task automatic expect_out(input string name, input int sel, input int fr, input int base,
                              input int width, input int chg);
        n_cmp++;
        if (int'(anim_sel) != sel || int'(frame_idx) != fr || int'(sheet_base) != base ||
            int'(sheet_width) != width || int'(anim_change) != chg) begin
            n_bad++;
            $display("FAIL %s got sel=%0d fr=%0d base=%0d w=%0d chg=%0d want sel=%0d fr=%0d base=%0d w=%0d chg=%0d",
                     name, anim_sel, frame_idx, sheet_base, sheet_width, anim_change, sel, fr, base, width, chg);
        end
    endtask

    typedef struct {
        bit    r, mv, j, og;
        int    n;
        int    sel, fr, base, width, chg;
        string name;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit r, input bit mv, input bit j, input bit og, input int n,
                       input int sel, input int fr, input int chg, input string name);
        vec_t v;
        v.r = r; v.mv = mv; v.j = j; v.og = og; v.n = n;
        v.sel = sel; v.fr = fr; v.chg = chg; v.name = name;
        v.base  = (sel == 0) ? 4096 : (sel == 1) ? 8192 : 14336;
        v.width = (sel == 0) ? 128 : (sel == 1) ? 192 : 256;
        vt.push_back(v);
    endtask

    initial begin
        bit mv, j, og, r;
        dl[0] = NEUT; dl[1] = NEUT; dl[2] = NEUT;

        //   r mv j og  n  sel fr chg
        add(1, 0, 0, 1,  2, 0, 0, 0, "reset");
        add(0, 0, 0, 1,  4, 0, 1, 0, "idle_f1");
        add(0, 0, 0, 1,  4, 0, 2, 0, "idle_f2");
        add(0, 0, 0, 1,  4, 0, 3, 0, "idle_f3");
        add(0, 0, 0, 1,  4, 0, 0, 0, "idle_wrap");
        add(0, 1, 0, 1,  2, 0, 0, 0, "walk_sync");
        add(0, 1, 0, 1,  1, 1, 0, 1, "walk_enter");
        add(0, 1, 0, 1,  4, 1, 1, 0, "walk_f1");
        add(0, 1, 0, 1, 16, 1, 5, 0, "walk_f5");
        add(0, 1, 0, 1,  4, 1, 0, 0, "walk_wrap");
        add(0, 1, 0, 0,  2, 1, 0, 0, "ledge_sync");
        add(0, 1, 0, 0,  1, 2, 4, 1, "ledge_fall");
        add(0, 1, 0, 0,  4, 2, 5, 0, "ledge_f5");
        add(0, 1, 0, 0,  4, 2, 6, 0, "ledge_f6");
        add(0, 1, 0, 0,  8, 2, 6, 0, "ledge_hold");
        add(0, 0, 0, 1,  3, 2, 7, 1, "land_enter");
        add(0, 0, 0, 1,  3, 2, 7, 0, "land_hold");
        add(0, 0, 0, 1,  1, 0, 0, 1, "land_exit");
        add(0, 0, 1, 1,  2, 0, 0, 0, "jump_sync");
        add(0, 0, 1, 1,  1, 2, 0, 1, "rise_enter");
        add(0, 0, 1, 1,  4, 2, 1, 0, "rise_f1");
        add(0, 0, 1, 1,  4, 2, 2, 0, "rise_f2");
        add(0, 0, 1, 1,  4, 2, 3, 0, "rise_f3");
        add(0, 0, 1, 1, 16, 2, 3, 0, "rise_hold");
        add(0, 0, 0, 0,  2, 2, 3, 0, "fall_sync");
        add(0, 0, 0, 0,  1, 2, 4, 1, "fall_enter");
        add(0, 0, 0, 0,  4, 2, 5, 0, "fall_f5");
        add(0, 0, 0, 0,  4, 2, 6, 0, "fall_f6");
        add(0, 0, 0, 0, 10, 2, 6, 0, "fall_hold");
        add(0, 0, 0, 1,  2, 2, 6, 0, "land2_sync");
        add(0, 0, 0, 1,  1, 2, 7, 1, "land2_enter");
        add(0, 0, 0, 1,  3, 2, 7, 0, "land2_hold");
        add(0, 0, 0, 1,  1, 0, 0, 1, "land2_exit");

        foreach (vt[k]) begin
            hold(vt[k].r, vt[k].mv, vt[k].j, vt[k].og, vt[k].n);
            expect_out(vt[k].name, vt[k].sel, vt[k].fr, vt[k].base, vt[k].width, vt[k].chg);
        end

        // Jump raised during LAND: straight to RISE, prescaler restarts.
        hold(0, 0, 0, 0, 3);  expect_out("l_fall",      2, 4, 14336, 256, 1);
        hold(0, 0, 0, 1, 3);  expect_out("l_land",      2, 7, 14336, 256, 1);
        hold(0, 0, 1, 1, 2);  expect_out("l_land_hold", 2, 7, 14336, 256, 0);
        hold(0, 0, 1, 1, 1);  expect_out("l_rise",      2, 0, 14336, 256, 1);
        hold(0, 0, 1, 1, 3);  expect_out("l_clear",     2, 0, 14336, 256, 0);
        hold(0, 0, 1, 1, 1);  expect_out("l_step",      2, 1, 14336, 256, 0);

        // Reset while falling at frame 5: back to IDLE at once, no stale edge afterwards.
        hold(1, 0, 0, 1, 1);  expect_out("r_rst1",      0, 0, 4096, 128, 0);
        hold(0, 0, 0, 1, 4);  expect_out("r_idle",      0, 1, 4096, 128, 0);
        hold(0, 0, 0, 0, 3);  expect_out("r_fall",      2, 4, 14336, 256, 1);
        hold(0, 0, 0, 0, 4);  expect_out("r_fall5",     2, 5, 14336, 256, 0);
        hold(1, 0, 0, 0, 1);  expect_out("r_reset",     0, 0, 4096, 128, 0);
        hold(0, 0, 0, 0, 1);  expect_out("r_noedge",    0, 0, 4096, 128, 0);

        // Reset in mid-jump with jumping still held high.
        hold(0, 0, 1, 1, 6);
        hold(1, 0, 1, 0, 1);  expect_out("rj_reset",    0, 0, 4096, 128, 0);
        hold(0, 0, 1, 0, 1);  expect_out("rj_next",     0, 0, 4096, 128, 0);

        // Random slowly-varying inputs with occasional reset, checked against the model.
        mv = 0; j = 0; og = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) mv = ~mv;
            if ($urandom_range(0, 7) == 0) j  = ~j;
            if ($urandom_range(0, 6) == 0) og = ~og;
            r = ($urandom_range(0, 299) == 0);
            cyc(r, mv, j, og);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
